// File: rtl/ram_pkg.sv
// Shared types and constants for the parametrised two-port RAM.
package ram_pkg;

    typedef enum logic {CLEAR = 1'b0, READY = 1'b1} ram_state_t;

    // Read-during-write behaviour selectors for RDW_MODE.
    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

endpackage

// File: rtl/param_ram_2port.sv
// Simple dual-port RAM with a registered read, a read-valid strobe and a hardware
// clear sweep that zeroes every location after reset or on request.
module param_ram_2port
    import ram_pkg::*;
#(
    parameter int DATA_W   = 4,
    parameter int ADDR_W   = 5,
    parameter int RDW_MODE = RDW_OLD
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear_req,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    ram_state_t        state_reg, state_next;
    logic [ADDR_W-1:0] clr_addr_reg, clr_addr_next;
    logic              clr_last;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              rd_fire;
    logic [DATA_W-1:0] rd_word;

    // Terminal count is the all-ones address, so the counter never needs an extra bit.
    assign clr_last = &clr_addr_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= CLEAR;
            clr_addr_reg <= '0;
        end else begin
            state_reg    <= state_next;
            clr_addr_reg <= clr_addr_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        clr_addr_next = clr_addr_reg;
        case (state_reg)
            CLEAR: begin
                clr_addr_next = clr_addr_reg + 1'b1;
                if (clr_last) begin
                    state_next = READY;
                end
            end
            READY: begin
                if (clear_req) begin
                    state_next = CLEAR;
                end
            end
            default: state_next = CLEAR;
        endcase
    end

    // clear_req wins over a same-cycle user write or read.
    always_comb begin
        busy      = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        rd_fire   = 1'b0;
        case (state_reg)
            CLEAR: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_waddr = clr_addr_reg;
                mem_wdata = '0;
            end
            READY: begin
                mem_we  = wr_en & ~clear_req;
                rd_fire = rd_en & ~clear_req;
            end
            default: busy = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    generate
        if (RDW_MODE == RDW_NEW) begin : g_rdw_new
            assign rd_word = (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
        end else begin : g_rdw_old
            assign rd_word = mem[rd_addr];
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_fire;
            if (rd_fire) begin
                rd_data <= rd_word;
            end
        end
    end

endmodule

// File: tb/tb_param_ram_2port.sv
// Drives three RAM configurations with shared stimulus and scores each against its
// own array-based reference model.
module tb_param_ram_2port;

    localparam int NDUT = 3;
    localparam int         DEPTH_C [NDUT] = '{32, 32, 8};
    localparam logic [7:0] DMASK_C [NDUT] = '{8'h0F, 8'h0F, 8'hFF};
    localparam int         MODE_C  [NDUT] = '{0, 1, 0};

    logic       clock;
    logic       reset_n;
    logic       clear_req;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [4:0] rd_addr;

    logic [3:0] rd0, rd1;
    logic [7:0] rd2;
    logic       val0, val1, val2;
    logic       busy0, busy1, busy2;

    logic [7:0] dut_data  [NDUT];
    logic       dut_valid [NDUT];
    logic       dut_busy  [NDUT];

    assign dut_data[0]  = {4'h0, rd0};
    assign dut_data[1]  = {4'h0, rd1};
    assign dut_data[2]  = rd2;
    assign dut_valid[0] = val0;
    assign dut_valid[1] = val1;
    assign dut_valid[2] = val2;
    assign dut_busy[0]  = busy0;
    assign dut_busy[1]  = busy1;
    assign dut_busy[2]  = busy2;

    param_ram_2port #(.DATA_W(4), .ADDR_W(5), .RDW_MODE(0)) u_old (
        .clock(clock), .reset_n(reset_n), .clear_req(clear_req),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data[3:0]),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd0), .rd_valid(val0), .busy(busy0)
    );

    param_ram_2port #(.DATA_W(4), .ADDR_W(5), .RDW_MODE(1)) u_new (
        .clock(clock), .reset_n(reset_n), .clear_req(clear_req),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data[3:0]),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd1), .rd_valid(val1), .busy(busy1)
    );

    param_ram_2port #(.DATA_W(8), .ADDR_W(3), .RDW_MODE(0)) u_small (
        .clock(clock), .reset_n(reset_n), .clear_req(clear_req),
        .wr_en(wr_en), .wr_addr(wr_addr[2:0]), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr[2:0]),
        .rd_data(rd2), .rd_valid(val2), .busy(busy2)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference model state: memory image, remaining sweep edges, expected outputs.
    logic [7:0] mdl_mem   [NDUT][32];
    int         sweep_left[NDUT];
    logic       exp_busy  [NDUT];
    logic       exp_valid [NDUT];
    logic [7:0] exp_data  [NDUT];
    logic [7:0] exp_q     [NDUT][$];

    int  n_cmp = 0;
    int  n_bad = 0;
    bit  mon_en = 1'b0;

    task automatic check(input string name, input int k, input logic [7:0] act,
                         input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d t=%0t: got %0h required %0h", name, k, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NDUT; k++) begin
            sweep_left[k] = DEPTH_C[k];
            exp_busy[k]   = 1'b1;
            exp_valid[k]  = 1'b0;
            exp_data[k]   = 8'h00;
            exp_q[k].delete();
            for (int a = 0; a < 32; a++) mdl_mem[k][a] = 8'h00;
        end
    endtask

    // Effect of the coming rising edge on each model, given the inputs now applied.
    task automatic model_edge();
        int         wa, ra;
        logic [7:0] wd, v;
        if (!reset_n) return;
        for (int k = 0; k < NDUT; k++) begin
            if (sweep_left[k] > 0) begin
                sweep_left[k]--;
                exp_valid[k] = 1'b0;
            end else if (clear_req) begin
                sweep_left[k] = DEPTH_C[k];
                exp_valid[k]  = 1'b0;
                for (int a = 0; a < 32; a++) mdl_mem[k][a] = 8'h00;
            end else begin
                wa = int'(wr_addr) % DEPTH_C[k];
                ra = int'(rd_addr) % DEPTH_C[k];
                wd = wr_data & DMASK_C[k];
                if (rd_en) begin
                    v = mdl_mem[k][ra];
                    if (MODE_C[k] == 1 && wr_en && wa == ra) v = wd;
                    exp_q[k].push_back(v);
                    exp_data[k]  = v;
                    exp_valid[k] = 1'b1;
                end else begin
                    exp_valid[k] = 1'b0;
                end
                if (wr_en) mdl_mem[k][wa] = wd;
            end
            exp_busy[k] = (sweep_left[k] > 0);
        end
    endtask

    // Monitor: pops the scoreboard whenever a DUT presents rd_valid.
    always @(negedge clock) begin
        if (mon_en) begin
            for (int k = 0; k < NDUT; k++) begin
                check("busy", k, {7'b0, dut_busy[k]}, {7'b0, exp_busy[k]});
                check("rd_valid", k, {7'b0, dut_valid[k]}, {7'b0, exp_valid[k]});
                check("rd_data_hold", k, dut_data[k], exp_data[k]);
                if (dut_valid[k] === 1'b1) begin
                    if (exp_q[k].size() == 0) begin
                        check("unexpected_read", k, 8'h01, 8'h00);
                    end else begin
                        logic [7:0] e;
                        e = exp_q[k].pop_front();
                        check("read_data", k, dut_data[k], e);
                        $display("read dut%0d t=%0t data=%0h expected=%0h", k, $time, dut_data[k], e);
                    end
                end
            end
        end
    end

    task automatic cycle(input logic c, input logic we, input logic [4:0] wa,
                         input logic [7:0] wd, input logic re, input logic [4:0] ra);
        clear_req = c;
        wr_en     = we;
        wr_addr   = wa;
        wr_data   = wd;
        rd_en     = re;
        rd_addr   = ra;
        model_edge();
        @(negedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 5'd0);
    endtask

    initial begin
        clear_req = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_en     = 1'b0;
        rd_addr   = '0;
        reset_n   = 1'b0;
        model_reset();
        mon_en    = 1'b1;

        // Reset sweep; random port activity while busy must be ignored.
        idle(2);
        reset_n = 1'b1;
        for (int i = 0; i < 32; i++)
            cycle(1'b0, 1'($urandom), 5'($urandom), 8'($urandom), 1'($urandom), 5'($urandom));
        idle(2);
        cycle(1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 5'd7);
        idle(1);

        // Basic write then read, then hold.
        cycle(1'b0, 1'b1, 5'd2, 8'hAA, 1'b0, 5'd0);
        cycle(1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 5'd2);
        idle(2);

        // Same-address read during write.
        cycle(1'b0, 1'b1, 5'd5, 8'h33, 1'b0, 5'd0);
        cycle(1'b0, 1'b1, 5'd5, 8'hCC, 1'b1, 5'd5);
        cycle(1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 5'd5);
        idle(1);

        // Fill, clear with a competing write, read everything back.
        for (int a = 0; a < 32; a++) cycle(1'b0, 1'b1, 5'(a), 8'(a), 1'b0, 5'd0);
        cycle(1'b1, 1'b1, 5'd9, 8'hFF, 1'b1, 5'd9);
        cycle(1'b1, 1'b0, 5'd0, 8'h00, 1'b0, 5'd0);
        idle(31);
        for (int a = 0; a < 32; a++) cycle(1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 5'(a));
        idle(1);

        // Reset in the middle of a requested sweep.
        cycle(1'b1, 1'b0, 5'd0, 8'h00, 1'b0, 5'd0);
        idle(9);
        reset_n = 1'b0;
        model_reset();
        idle(1);
        reset_n = 1'b1;
        for (int i = 0; i < 32; i++) cycle(1'b0, 1'b1, 5'd1, 8'h5A, 1'b1, 5'd1);
        cycle(1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 5'd1);
        idle(1);

        // Wide/shallow configuration corner: top address all-ones data.
        cycle(1'b0, 1'b1, 5'd7, 8'hFF, 1'b0, 5'd0);
        cycle(1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 5'd7);
        cycle(1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 5'd0);
        idle(1);

        // Randomised traffic with occasional clear requests.
        for (int i = 0; i < 800; i++)
            cycle(1'($urandom_range(0, 99) == 0), 1'($urandom), 5'($urandom), 8'($urandom),
                  1'($urandom), 5'($urandom));
        idle(3);

        mon_en = 1'b0;
        for (int k = 0; k < NDUT; k++)
            check("queue_drained", k, 8'(exp_q[k].size()), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/param_ram_2port.md
Name: param_ram_2port

Overview:
- Parametrised simple-dual-port RAM: one write port and one read port, both on the same clock.
- Successor to the fixed 32x4 board RAM. Adds:
  - generic width and depth
  - registered read with a valid strobe
  - selectable read-during-write collision mode
  - hardware clear sweep that zeroes every location after reset or on request
- Sits between switch/FSM front-ends and HEX display logic in lab tops.

Parameters:
- DATA_W, 4: data word width in bits.
- ADDR_W, 5: address width in bits; DEPTH = 2**ADDR_W.
- RDW_MODE, 0: same-address read-during-write behaviour. 0 = read returns old data; 1 = write-through (read returns new data).

Ports:
- clock, input, 1: single clock; all state updates on rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- clear_req, input, 1: pulse high for one cycle in READY to start a clear sweep.
- wr_en, input, 1: write enable.
- wr_addr, input, ADDR_W: write address.
- wr_data, input, DATA_W: write data.
- rd_en, input, 1: read request.
- rd_addr, input, ADDR_W: read address.
- rd_data, output, DATA_W: registered read data.
- rd_valid, output, 1: high for one cycle when rd_data is updated by an accepted read.
- busy, output, 1: high while the clear sweep runs; ports are ignored while high.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state = CLEAR, clr_addr = 0, rd_data = 0, rd_valid = 0, busy = 1.
  - Array contents are not reset directly; the sweep zeroes them.
- FSM states, two:
  - CLEAR: each rising edge writes 0 to mem[clr_addr] and increments clr_addr. On the edge that writes DEPTH-1, go to READY, clr_addr wraps to 0, busy goes 0.
  - READY: normal operation. clear_req = 1 goes to CLEAR on the next edge with busy = 1, and that edge also performs no user write.
- Clear timing: busy is high for exactly DEPTH rising edges after reset release or after the clear_req edge.
- CLEAR state restrictions:
  - wr_en and rd_en are ignored.
  - rd_valid stays 0.
  - rd_data holds its last value.
- Write (READY, wr_en = 1): mem[wr_addr] <= wr_data on the rising edge.
- Read (READY, rd_en = 1): on the edge, rd_data <= mem[rd_addr] and rd_valid <= 1. Latency is 1 cycle.
- Read with rd_en = 0: rd_valid <= 0, rd_data holds.
- Collision (wr_en, rd_en and wr_addr == rd_addr on the same edge):
  - RDW_MODE = 0: rd_data gets the pre-write contents.
  - RDW_MODE = 1: rd_data gets wr_data.
  - In both modes the write commits.
- clear_req together with wr_en/rd_en in READY: clear_req wins. No write, no read, rd_valid <= 0.
- clear_req while busy: ignored; the sweep does not restart.
- Reset mid-sweep: the sweep restarts from address 0 after release, and the full DEPTH-cycle busy window repeats.
- Width rules:
  - clr_addr is ADDR_W bits wide.
  - The terminal-count compare is against all-ones; there is no DEPTH+1 bit counter.
- Addresses are always in range; there are no out-of-range conditions.

Decomposition:
- Shared package ram_pkg holds:
  - typedef enum logic {CLEAR, READY} ram_state_t
  - constants RDW_OLD = 0 and RDW_NEW = 1, used by RDW_MODE
- No sub-module: the array, FSM and read register form a single module.
- Board top-level wrappers instantiate it with the existing hex display decoder.

Test Plan:
- Reset sweep: hold reset_n low 2 cycles, release. busy is 1 for exactly 32 edges, then 0. A read of addr 7 then returns 0 with rd_valid = 1 one cycle later.
- Basic write/read: write 4'hA to addr 2. Next cycle read addr 2: rd_data = 4'hA and rd_valid = 1 one edge later. The cycle after, with rd_en = 0, rd_valid = 0 and rd_data holds 4'hA.
- Collision: addr 5 holds 4'h3. Same-edge write of 4'hC and read of addr 5. RDW_MODE = 0 gives rd_data = 4'h3, RDW_MODE = 1 gives 4'hC. A follow-up read returns 4'hC in both modes.
- Clear request: fill addrs 0..31 with addr[3:0], then pulse clear_req with wr_en = 1 to addr 9, data 4'hF. busy is high 32 edges and all reads afterwards return 0, including addr 9.
- Reset mid-sweep: pulse clear_req, assert reset_n low at sweep edge 10, release. busy stays high a full 32 edges from release. Inputs applied during busy (wr_en to addr 1, rd_en) cause no write and no rd_valid.
- Parameter sweep: DATA_W = 8, ADDR_W = 3. busy lasts 8 edges. Writing 8'hFF to addr 7 and reading it back returns 8'hFF; addr 0 still reads 0.
